// File: rtl/offset_pkg.sv
// Shared constants and state type for the OFFSET sequencer.
package offset_pkg;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int ADDR_W = 13;
  localparam int PIX_W  = 8;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  // All-ones address: OFFSET forwards it as a "no access" marker.
  localparam logic signed [ADDR_W-1:0] NO_ACCESS = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/offset_seq_ctrl.sv
// Raster-order sequencer for the OFFSET address unit: three vertical reads
// per base pixel, packed into one column window handed downstream.
// Optional feature: OFFSET_SEQ_PAD_EN extends the walk to every row and
// zero-fills slots that fall below the image instead of reading them.
module offset_seq_ctrl
  import offset_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic signed [ADDR_W-1:0] base_addr,
  output logic [1:0]               cnt,
  output logic                     rd_req,
  input  logic                     rd_ack,
  input  logic [PIX_W-1:0]         rd_data,
  output logic                     win_valid,
  output logic [3*PIX_W-1:0]       win_data,
  input  logic                     win_ready
);

`ifdef OFFSET_SEQ_PAD_EN
  localparam int YMAX = IMG_H - 1;
`else
  localparam int YMAX = IMG_H - 3;
`endif

  localparam logic signed [ADDR_W-1:0] ADDR_ONE = 1;

  state_e                      state_q, state_d;
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;
  logic signed [ADDR_W-1:0]    base_q, base_d;
  logic [1:0]                  k_q, k_d;
  logic [2:0][PIX_W-1:0]       slot_q, slot_d;
  logic                        pad_skip;
  logic                        last_base;

`ifdef OFFSET_SEQ_PAD_EN
  logic [YW:0] row_sum;
  // Slot row lies below the image: skip the read and zero-fill.
  always_comb begin
    row_sum  = {1'b0, y_q} + (YW+1)'(k_q);
    pad_skip = (row_sum >= (YW+1)'(IMG_H));
  end
`else
  assign pad_skip = 1'b0;
`endif

  assign last_base = (x_q == XW'(IMG_W-1)) && (y_q == YW'(YMAX));
  assign win_data  = slot_q;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      k_q     <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      k_q     <= k_d;
      slot_q  <= slot_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    base_d    = base_q;
    k_d       = k_q;
    slot_d    = slot_q;
    busy      = 1'b0;
    done      = 1'b0;
    base_addr = NO_ACCESS;
    cnt       = 2'd0;
    rd_req    = 1'b0;
    win_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          k_d     = 2'd0;
        end
      end

      ISSUE: begin
        busy = 1'b1;
        if (pad_skip || rd_ack) begin
          // Padded slots spend their cycle with no request outstanding.
          slot_d[k_q] = pad_skip ? '0 : rd_data;
          if (k_q == 2'd2) state_d = EMIT;
          else             k_d     = k_q + 2'd1;
        end
        if (!pad_skip) begin
          rd_req    = 1'b1;
          base_addr = base_q;
          cnt       = k_q;
        end
      end

      EMIT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready) begin
          // Row stride equals image width, so +1 also crosses row ends.
          base_d = base_q + ADDR_ONE;
          if (x_q == XW'(IMG_W-1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          k_d     = 2'd0;
          state_d = last_base ? DONE : ISSUE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_offset_seq_ctrl.sv
// Scoreboard bench for offset_seq_ctrl with a random-latency memory model.
module tb_offset_seq_ctrl;

`ifdef OFFSET_SEQ_PAD_EN
  localparam int YMAX = 63;
  localparam int NWIN = 64 * 64;
`else
  localparam int YMAX = 61;
  localparam int NWIN = 64 * 62;
`endif

  logic               clk = 1'b0;
  logic               rst, start, busy, done, rd_req, rd_ack, win_valid, win_ready;
  logic signed [12:0] base_addr;
  logic [1:0]         cnt;
  logic [7:0]         rd_data;
  logic [23:0]        win_data;

  offset_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .base_addr(base_addr), .cnt(cnt), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .win_valid(win_valid), .win_data(win_data),
    .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [4096];
  logic [23:0] exp_win[$];
  int          exp_rd[$];
  int          n_chk = 0, n_err = 0;
  int          win_cnt = 0, done_cnt = 0, max_addr = 0;
  int          max_dly = 0;
  bit          spur_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference frame: every base pixel in raster order, rows below the image read as 0.
  task automatic build_frame();
    exp_win.delete();
    exp_rd.delete();
    for (int y = 0; y <= YMAX; y++)
      for (int x = 0; x < 64; x++) begin
        logic [23:0] w;
        w = '0;
        for (int k = 0; k < 3; k++)
          if (y + k < 64) begin
            w[k*8 +: 8] = mem[(y+k)*64 + x];
            exp_rd.push_back((y+k)*64 + x);
          end
        exp_win.push_back(w);
      end
    win_cnt  = 0;
    done_cnt = 0;
    max_addr = 0;
  endtask

  // Memory responder: random ack delay, optional acks with no request outstanding.
  initial begin
    int dly;
    logic [11:0] a;
    dly = 0;
    rd_ack = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (rd_req) begin
        if (dly == 0) begin
          a = 12'(int'(base_addr) + int'(cnt) * 64);
          rd_ack  = 1'b1;
          rd_data = mem[a];
          dly = $urandom_range(0, max_dly);
        end else dly--;
      end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
        rd_ack  = 1'b1;
        rd_data = 8'($urandom);
      end
    end
  end

  // Monitor: reads, windows and done pulses checked against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (rd_req) begin
        chk("cnt_range", {63'd0, cnt == 2'd3}, 64'd0);
        if (rd_ack) begin
          int a;
          a = int'(base_addr) + int'(cnt) * 64;
          if (a > max_addr) max_addr = a;
          if (exp_rd.size() == 0) chk("rd_extra", 64'(a), 64'hFFFF_FFFF);
          else chk("rd_addr", 64'(a), 64'(exp_rd.pop_front()));
        end
      end else begin
        chk("noreq_base", {51'd0, base_addr}, 64'h1FFF);
      end
      if (win_valid && win_ready) begin
`ifdef OFFSET_SEQ_PAD_EN
        if (win_cnt == 63*64 + 5) chk("pad_win", {40'd0, win_data}, {40'd0, 16'd0, mem[4037]});
`endif
        win_cnt++;
        if (exp_win.size() == 0) chk("win_extra", {40'd0, win_data}, 64'hFFFF_FFFF);
        else chk("win_data", {40'd0, win_data}, {40'd0, exp_win.pop_front()});
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    for (t = 0; t < 60000; t++) begin
      @(negedge clk); #3;
      if (done_cnt > 0) break;
    end
    chk({nm, "_timeout"}, 64'(t >= 60000), 64'd0);
    repeat (3) @(negedge clk);
    #3;
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, "_win_cnt"}, 64'(win_cnt), 64'(NWIN));
    chk({nm, "_left"}, 64'(exp_win.size() + exp_rd.size()), 64'd0);
    chk({nm, "_max_addr"}, 64'(max_addr), 64'd4095);
    chk({nm, "_busy_end"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [23:0] cap;
    int n_req, i;
    rst = 1'b1; start = 1'b0; win_ready = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_base", {51'd0, base_addr}, 64'h1FFF);
    chk("rst_cnt", {62'd0, cnt}, 64'd0);
    chk("rst_req", {63'd0, rd_req}, 64'd0);
    chk("rst_wv", {63'd0, win_valid}, 64'd0);
    chk("rst_wd", {40'd0, win_data}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Frame 1: zero-latency acks, first window stalled, spurious start
    max_dly = 0; spur_en = 0;
    build_frame();
    pulse_start();
    n_req = 0;
    for (i = 0; i < 50; i++) begin
      #2;
      if (rd_req) n_req++;
      if (win_valid) break;
      @(negedge clk);
    end
    chk("first_win_seen", 64'(i >= 50), 64'd0);
    chk("first_req_cycles", 64'(n_req), 64'd3);
    cap = win_data;
    chk("first_win", {40'd0, cap}, {40'd0, mem[128], mem[64], mem[0]});
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      if (s == 3) start = 1'b1;
      if (s == 4) start = 1'b0;
      #2;
      chk("stall_wv", {63'd0, win_valid}, 64'd1);
      chk("stall_wd", {40'd0, win_data}, {40'd0, cap});
      chk("stall_req", {63'd0, rd_req}, 64'd0);
    end
    win_ready = 1'b1;
    wait_done("f1");

    // Frame 2: random 0-3 cycle ack latency, stray acks between requests
    max_dly = 3; spur_en = 1;
    build_frame();
    pulse_start();
    wait_done("f2");

    // Frame 3: reset while a read is outstanding, then restart
    spur_en = 0;
    build_frame();
    pulse_start();
    repeat (40) @(negedge clk);
    for (i = 0; i < 20; i++) begin
      #2;
      if (rd_req) break;
      @(negedge clk);
    end
    chk("mid_req_seen", 64'(i >= 20), 64'd0);
    rst = 1'b1;
    #1;
    chk("arst_req", {63'd0, rd_req}, 64'd0);
    chk("arst_wv", {63'd0, win_valid}, 64'd0);
    chk("arst_base", {51'd0, base_addr}, 64'h1FFF);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    exp_win.delete();
    exp_rd.delete();
    @(negedge clk); rst = 1'b0;
    build_frame();
    pulse_start();
    for (i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (win_cnt > 0) break;
    end
    chk("restart_win", 64'(win_cnt > 0), 64'd1);
    chk("restart_no_done", 64'(done_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
